// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Bit timing comes from an internal 16-bit counter; all outputs are registered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for tx_start
// S_START  | start bit (low) for one bit period
// S_DATA   | data bit idx_q of the latched byte
// S_PARITY | parity bit, present only when PARITY_EN=1
// S_STOP   | stop bit idx_q (high); the last clk of the last one is tx_done
module uart_tx_module #(
  parameter int unsigned CLKS_PER_BIT = 5120,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wrap;
  logic        accept;
  logic [7:0]  data_masked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    accept      = 1'b0;
    wrap        = (cnt_q == CNT_LAST);
    data_masked = tx_data & DATA_MASK;

    if (state_q != S_IDLE) begin
      cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        accept = tx_start;
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = 3'd0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          idx_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            // A request in the tx_done cycle chains straight into the next start bit.
            accept  = tx_start;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = S_START;
      cnt_d    = 16'd0;
      idx_d    = 3'd0;
      shift_d  = data_masked;
      parity_d = (^data_masked) ^ PARITY_ODD;
    end

    // Outputs are registered from the next state so they line up with state_q.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[idx_d];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: four instances with different framing run concurrently,
// checked every cycle against a frame-position model plus literal bit patterns and lengths.
module tb_uart_tx_module;

  localparam int CPB [4] = '{5120, 16, 16, 16};
  localparam int PEN [4] = '{0, 1, 1, 0};
  localparam int POD [4] = '{0, 0, 1, 0};

  logic       clk;
  logic [3:0] rst;
  logic [3:0] start;
  logic [7:0] data [4];
  logic       tx_w [4];
  logic       busy_w [4];
  logic       done_w [4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ndone [4] = '{0, 0, 0, 0};

  // model: frame bits and current position (clks) within the frame
  bit          act [4];
  int          pos [4];
  logic [15:0] fr  [4];

  bit pat55  [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  bit patA5e [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  bit patA5o [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};

  uart_tx_module u_def (
    .clk(clk), .reset_n(rst[0]), .tx_start(start[0]), .tx_data(data[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_module #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe (
    .clk(clk), .reset_n(rst[1]), .tx_start(start[1]), .tx_data(data[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_module #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
    .clk(clk), .reset_n(rst[2]), .tx_start(start[2]), .tx_data(data[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_module #(.CLKS_PER_BIT(16)) u_fr (
    .clk(clk), .reset_n(rst[3]), .tx_start(start[3]), .tx_data(data[3]),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int flen(input int k);
    return (1 + 8 + PEN[k] + 1) * CPB[k];
  endfunction

  function automatic logic [15:0] make_frame(input int k, input logic [7:0] d);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = d[i];
      p        = p ^ d[i];
    end
    if (PEN[k] != 0) f[9] = p ^ (POD[k] != 0);
    return f;
  endfunction

  function automatic void chk(input string name, input int k, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", name, k, cyc, act_v, exp_v);
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (!rst[k]) begin
        act[k] <= 1'b0;
        pos[k] <= 0;
      end else if (act[k] && pos[k] != flen(k) - 1) begin
        pos[k] <= pos[k] + 1;
      end else if (start[k]) begin
        act[k] <= 1'b1;
        pos[k] <= 0;
        fr[k]  <= make_frame(k, data[k]);
      end else begin
        act[k] <= 1'b0;
        pos[k] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic e_tx, e_busy, e_done;
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (rst[k] && act[k]) begin
        e_tx   = fr[k][pos[k] / CPB[k]];
        e_busy = 1'b1;
        e_done = (pos[k] == flen(k) - 1);
      end
      chk("model_tx", k, int'(tx_w[k]), int'(e_tx));
      chk("model_busy", k, int'(busy_w[k]), int'(e_busy));
      chk("model_done", k, int'(done_w[k]), int'(e_done));
      if (done_w[k]) ndone[k] <= ndone[k] + 1;
    end
    if (n_errors > 40) begin
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  // which: 0 = wait for tx low, 1 = wait for tx_done high
  task automatic wait_sig(input int k, input int which, input int budget, output int at);
    bit found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((which == 0 && tx_w[k] == 1'b0) || (which == 1 && done_w[k] == 1'b1)) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait[%0d] event %0d: not seen within %0d clks", k, which, budget);
    end
  endtask

  task automatic pulse(input int k, input logic [7:0] d);
    @(posedge clk);
    #2;
    start[k] = 1'b1;
    data[k]  = d;
    @(posedge clk);
    #2;
    start[k] = 1'b0;
  endtask

  task automatic run_parity(input int k);
    int f, d, cur, tgt;
    repeat (10) @(posedge clk);
    pulse(k, 8'hA5);
    wait_sig(k, 0, 10, f);
    cur = 0;
    for (int i = 0; i < 11; i++) begin
      tgt = i * 16 + 8;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      chk(k == 1 ? "even_bit" : "odd_bit", k, int'(tx_w[k]), k == 1 ? int'(patA5e[i]) : int'(patA5o[i]));
    end
    wait_sig(k, 1, 16, d);
    // tx_done fills the frame's last clk, so the edge after it is one frame from the fall
    chk("par_len", k, d + 1 - f, 176);
  endtask

  initial begin
    int f, d, d1, d2, cur, tgt, n0;
    rst   = '0;
    start = '0;
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = '1;

    fork
      begin : def_frame
        repeat (200) @(posedge clk);
        chk("idle_tx", 0, int'(tx_w[0]), 1);
        chk("idle_busy", 0, int'(busy_w[0]), 0);
        pulse(0, 8'h55);
        wait_sig(0, 0, 10, f);
        cur = 0;
        for (int i = 0; i < 10; i++) begin
          tgt = i * 5120 + 2560;
          repeat (tgt - cur) @(negedge clk);
          cur = tgt;
          chk("def_bit", 0, int'(tx_w[0]), int'(pat55[i]));
        end
        wait_sig(0, 1, 5120, d);
        chk("def_len", 0, d + 1 - f, 51200);
        @(negedge clk);
        chk("def_busy_after", 0, int'(busy_w[0]), 0);
      end
      run_parity(1);
      run_parity(2);
      begin : framing
        int fa, da, n1;
        // back-to-back frames with tx_start held high
        repeat (10) @(posedge clk);
        #2;
        start[3] = 1'b1;
        data[3]  = 8'h00;
        wait_sig(3, 0, 10, fa);
        @(posedge clk);
        #2;
        data[3] = 8'hFF;
        wait_sig(3, 1, 200, d1);
        chk("b2b_first_len", 3, d1 + 1 - fa, 160);
        @(negedge clk);
        chk("b2b_no_gap_tx", 3, int'(tx_w[3]), 0);
        chk("b2b_busy", 3, int'(busy_w[3]), 1);
        @(posedge clk);
        #2;
        start[3] = 1'b0;
        wait_sig(3, 1, 200, d2);
        chk("b2b_period", 3, d2 - d1, 160);

        // mid-frame request is ignored
        repeat (20) @(posedge clk);
        n1 = ndone[3];
        pulse(3, 8'h96);
        wait_sig(3, 0, 10, fa);
        repeat (80) @(posedge clk);
        #2;
        start[3] = 1'b1;
        data[3]  = 8'h33;
        @(posedge clk);
        #2;
        start[3] = 1'b0;
        wait_sig(3, 1, 200, da);
        chk("mid_len", 3, da + 1 - fa, 160);
        repeat (50) @(posedge clk);
        chk("mid_one_done", 3, ndone[3], n1 + 1);

        // reset during data bit 3 aborts the frame
        n0 = ndone[3];
        pulse(3, 8'h00);
        wait_sig(3, 0, 10, fa);
        repeat (72) @(negedge clk);
        chk("rst_pre_tx", 3, int'(tx_w[3]), 0);
        @(posedge clk);
        #2;
        rst[3] = 1'b0;
        @(negedge clk);
        chk("rst_tx", 3, int'(tx_w[3]), 1);
        chk("rst_busy", 3, int'(busy_w[3]), 0);
        chk("rst_done", 3, int'(done_w[3]), 0);
        repeat (3) @(posedge clk);
        #2;
        rst[3] = 1'b1;
        repeat (40) @(posedge clk);
        chk("rst_no_done", 3, ndone[3], n0);
        pulse(3, 8'hC3);
        wait_sig(3, 0, 10, fa);
        wait_sig(3, 1, 200, da);
        chk("post_rst_len", 3, da + 1 - fa, 160);
        repeat (4) @(posedge clk);
        chk("post_rst_done", 3, ndone[3], n0 + 1);
      end
    join

    repeat (5) @(posedge clk);
    chk("total_done", 0, ndone[0], 1);
    chk("total_done", 1, ndone[1], 1);
    chk("total_done", 2, ndone[2], 1);
    chk("total_done", 3, ndone[3], 4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
